// File: rtl/mips_core_pkg.sv
// Shared core types and defaults for the rename slice.
package mips_core_pkg;

    localparam int unsigned NUM_ARCH_DEFAULT = 32;
    localparam int unsigned NUM_PHYS_DEFAULT = 64;
    localparam int unsigned NUM_CKPT_DEFAULT = 4;

    // Index width that never collapses to zero bits for tiny depths.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_w(NUM_ARCH_DEFAULT)-1:0] MipsReg;
    typedef logic [idx_w(NUM_PHYS_DEFAULT)-1:0] PhysReg;
    typedef logic [idx_w(NUM_CKPT_DEFAULT)-1:0] CkptId;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers with a wrap-bit pointer pair.
// Head can be reloaded from a checkpoint; tail only ever moves forward.
module rename_free_list
    import mips_core_pkg::*;
#(
    parameter  int unsigned NUM_ARCH   = NUM_ARCH_DEFAULT,
    parameter  int unsigned NUM_PHYS   = NUM_PHYS_DEFAULT,
    localparam int unsigned PW         = idx_w(NUM_PHYS),
    localparam int unsigned FREE_DEPTH = NUM_PHYS - NUM_ARCH,
    localparam int unsigned IDXW       = idx_w(FREE_DEPTH),
    localparam int unsigned PTRW       = IDXW + 1,
    localparam int unsigned CNTW       = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pop,
    input  logic            push,
    input  logic [PW-1:0]   push_phys,
    input  logic            restore,
    input  logic [PTRW-1:0] restore_head,
    output logic [PW-1:0]   head_data_c,
    output logic [PTRW-1:0] head_next_c,
    output logic [CNTW-1:0] count_c
);

    logic [PW-1:0]   fifo_q [FREE_DEPTH];
    logic [PTRW-1:0] head_q;
    logic [PTRW-1:0] tail_q;
    logic [PTRW-1:0] tail_next;
    logic            push_en;
    logic [CNTW-1:0] head_lin;
    logic [CNTW-1:0] tail_lin;

    // Advance a pointer, toggling the wrap bit when the index rolls over.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p[IDXW-1:0] == IDXW'(FREE_DEPTH - 1))
            return {~p[PTRW-1], IDXW'(0)};
        else
            return p + PTRW'(1);
    endfunction

    // Linear position of a pointer in [0, 2*FREE_DEPTH).
    function automatic logic [CNTW-1:0] ptr_lin(input logic [PTRW-1:0] p);
        if (p[PTRW-1])
            return CNTW'(FREE_DEPTH) + CNTW'(p[IDXW-1:0]);
        else
            return CNTW'(p[IDXW-1:0]);
    endfunction

    // Next pointers, head read data and occupancy.
    always_comb begin
        push_en     = push && (push_phys != '0);
        head_next_c = head_q;
        if (restore)
            head_next_c = restore_head;
        else if (pop)
            head_next_c = ptr_inc(head_q);
        tail_next   = push_en ? ptr_inc(tail_q) : tail_q;
        head_data_c = fifo_q[head_q[IDXW-1:0]];
        head_lin    = ptr_lin(head_q);
        tail_lin    = ptr_lin(tail_q);
        if (tail_lin >= head_lin)
            count_c = tail_lin - head_lin;
        else
            count_c = tail_lin + CNTW'(2 * FREE_DEPTH) - head_lin;
    end

    // Pointer and storage update; reset fills the list with the spare registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= {1'b1, IDXW'(0)};
            for (int i = 0; i < int'(FREE_DEPTH); i++)
                fifo_q[i] <= PW'(NUM_ARCH + i);
        end else begin
            head_q <= head_next_c;
            tail_q <= tail_next;
            if (push_en)
                fifo_q[tail_q[IDXW-1:0]] <= push_phys;
        end
    end

endmodule

// File: rtl/reg_rename_unit.sv
// Register rename stage: map table, free list and checkpoint slots for
// mispredict recovery. Optional perf counters under RENAME_PERF_CNT_EN.
module reg_rename_unit
    import mips_core_pkg::*;
#(
    parameter  int unsigned NUM_ARCH   = NUM_ARCH_DEFAULT,
    parameter  int unsigned NUM_PHYS   = NUM_PHYS_DEFAULT,
    parameter  int unsigned NUM_CKPT   = NUM_CKPT_DEFAULT,
    localparam int unsigned AW         = idx_w(NUM_ARCH),
    localparam int unsigned PW         = idx_w(NUM_PHYS),
    localparam int unsigned CW         = idx_w(NUM_CKPT),
    localparam int unsigned FREE_DEPTH = NUM_PHYS - NUM_ARCH,
    localparam int unsigned PTRW       = idx_w(FREE_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ren_valid,
    output logic          ren_ready,
    input  logic          uses_rs,
    input  logic          uses_rt,
    input  logic          uses_rw,
    input  logic [AW-1:0] rs_arch,
    input  logic [AW-1:0] rt_arch,
    input  logic [AW-1:0] rw_arch,
    output logic [PW-1:0] rs_phys,
    output logic [PW-1:0] rt_phys,
    output logic [PW-1:0] rw_phys,
    output logic [PW-1:0] prev_phys,
    output logic [AW-1:0] prev_arch,
    input  logic          commit_free_valid,
    input  logic [PW-1:0] commit_free_phys,
    input  logic          ckpt_take,
    input  logic [CW-1:0] ckpt_id,
    input  logic          restore_valid,
    input  logic [CW-1:0] restore_id,
    output logic [PW:0]   free_count
`ifdef RENAME_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [15:0]   restore_count
`endif
);

    logic [PW-1:0]   map_q      [NUM_ARCH];
    logic [PW-1:0]   map_d      [NUM_ARCH];
    logic [PW-1:0]   ckpt_map_q [NUM_CKPT][NUM_ARCH];
    logic [PTRW-1:0] ckpt_head_q[NUM_CKPT];

    logic            alloc;
    logic            fire;
    logic [PW-1:0]   fl_head_data;
    logic [PTRW-1:0] fl_head_next;
    logic [PW:0]     fl_count;

    rename_free_list #(
        .NUM_ARCH (NUM_ARCH),
        .NUM_PHYS (NUM_PHYS)
    ) u_free_list (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop          (fire && alloc),
        .push         (commit_free_valid),
        .push_phys    (commit_free_phys),
        .restore      (restore_valid),
        .restore_head (ckpt_head_q[restore_id]),
        .head_data_c  (fl_head_data),
        .head_next_c  (fl_head_next),
        .count_c      (fl_count)
    );

    // Handshake and lookups, all read from the map before this cycle's write.
    always_comb begin
        alloc      = uses_rw && (rw_arch != '0);
        ren_ready  = !restore_valid && ((fl_count != '0) || !alloc);
        fire       = ren_valid && ren_ready;
        rs_phys    = uses_rs ? map_q[rs_arch] : '0;
        rt_phys    = uses_rt ? map_q[rt_arch] : '0;
        rw_phys    = alloc ? fl_head_data : '0;
        prev_phys  = map_q[rw_arch];
        prev_arch  = rw_arch;
        free_count = fl_count;
    end

    // Next map: restore wins over a rename in the same cycle.
    always_comb begin
        map_d = map_q;
        if (restore_valid)
            map_d = ckpt_map_q[restore_id];
        else if (fire && alloc)
            map_d[rw_arch] = fl_head_data;
    end

    // Map table and checkpoint slots; a snapshot captures the post-rename state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ARCH); i++)
                map_q[i] <= PW'(i);
            for (int c = 0; c < int'(NUM_CKPT); c++) begin
                ckpt_head_q[c] <= '0;
                for (int i = 0; i < int'(NUM_ARCH); i++)
                    ckpt_map_q[c][i] <= PW'(i);
            end
        end else begin
            map_q <= map_d;
            if (ckpt_take && !restore_valid) begin
                ckpt_map_q[ckpt_id]  <= map_d;
                ckpt_head_q[ckpt_id] <= fl_head_next;
            end
        end
    end

`ifdef RENAME_PERF_CNT_EN
    // Saturating stall and restore counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            restore_count <= '0;
        end else begin
            if (ren_valid && !ren_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (restore_valid && (restore_count != '1))
                restore_count <= restore_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_rename_unit.sv
// Scoreboard bench for reg_rename_unit with an unbounded-log reference model.
module tb_reg_rename_unit;
    import mips_core_pkg::*;

    localparam int NA = 32;
    localparam int NP = 64;
    localparam int NC = 4;
    localparam int F  = NP - NA;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   ren_valid, ren_ready;
    logic   uses_rs, uses_rt, uses_rw;
    MipsReg rs_arch, rt_arch, rw_arch, prev_arch;
    PhysReg rs_phys, rt_phys, rw_phys, prev_phys;
    logic   commit_free_valid;
    PhysReg commit_free_phys;
    logic   ckpt_take, restore_valid;
    CkptId  ckpt_id, restore_id;
    logic [6:0] free_count;
`ifdef RENAME_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] restore_count;
`endif

    always #5 clk = ~clk;

    reg_rename_unit dut (
        .clk(clk), .rst_n(rst_n), .ren_valid(ren_valid), .ren_ready(ren_ready),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .uses_rw(uses_rw),
        .rs_arch(rs_arch), .rt_arch(rt_arch), .rw_arch(rw_arch),
        .rs_phys(rs_phys), .rt_phys(rt_phys), .rw_phys(rw_phys),
        .prev_phys(prev_phys), .prev_arch(prev_arch),
        .commit_free_valid(commit_free_valid), .commit_free_phys(commit_free_phys),
        .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
        .restore_valid(restore_valid), .restore_id(restore_id),
        .free_count(free_count)
`ifdef RENAME_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .restore_count(restore_count)
`endif
    );

    typedef struct {
        bit fire;
        bit ready;
        int rs, rt, rw, prev, arch, cnt;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    // Reference model: every free-list entry ever written is kept in a log and
    // addressed by unbounded head/tail counts.
    int m_map[NA];
    int ck_map[NC][NA];
    int ck_head[NC];
    int flog[$];
    int head_abs, tail_abs;
    int m_stall, m_rest;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) m_map[i] = i;
        for (int c = 0; c < NC; c++) begin
            ck_head[c] = 0;
            for (int i = 0; i < NA; i++) ck_map[c][i] = i;
        end
        flog.delete();
        for (int i = 0; i < F; i++) flog.push_back(NA + i);
        head_abs = 0;
        tail_abs = F;
        m_stall  = 0;
        m_rest   = 0;
    endtask

    task automatic idle_inputs();
        ren_valid = 0; uses_rs = 0; uses_rt = 0; uses_rw = 0;
        rs_arch = '0; rt_arch = '0; rw_arch = '0;
        commit_free_valid = 0; commit_free_phys = '0;
        ckpt_take = 0; ckpt_id = '0; restore_valid = 0; restore_id = '0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    // Apply one cycle of stimulus, queue the expected response, step the model.
    task automatic drive(input bit v, input bit urs, input bit urt, input bit urw,
                         input int rs, input int rt, input int rw,
                         input bit cv, input int cp, input bit ct, input int cid,
                         input bit rv, input int rid);
        exp_t e;
        int cnt;
        bit alloc, rdy, fire;
        @(posedge clk); #1;
        ren_valid = v; uses_rs = urs; uses_rt = urt; uses_rw = urw;
        rs_arch = MipsReg'(rs); rt_arch = MipsReg'(rt); rw_arch = MipsReg'(rw);
        commit_free_valid = cv; commit_free_phys = PhysReg'(cp);
        ckpt_take = ct; ckpt_id = CkptId'(cid);
        restore_valid = rv; restore_id = CkptId'(rid);

        alloc = urw && (rw != 0);
        cnt   = tail_abs - head_abs;
        rdy   = !rv && (cnt != 0 || !alloc);
        fire  = v && rdy;
        e.fire  = fire;
        e.ready = rdy;
        e.rs    = urs ? m_map[rs] : 0;
        e.rt    = urt ? m_map[rt] : 0;
        e.rw    = (alloc && cnt > 0) ? flog[head_abs] : 0;
        e.prev  = m_map[rw];
        e.arch  = rw;
        e.cnt   = cnt;
        sb.push_back(e);

        if (v && !rdy) m_stall++;
        if (rv) begin
            m_rest++;
            m_map    = ck_map[rid];
            head_abs = ck_head[rid];
        end else begin
            if (fire && alloc) begin
                m_map[rw] = flog[head_abs];
                head_abs++;
            end
            if (ct) begin
                ck_map[cid]  = m_map;
                ck_head[cid] = head_abs;
            end
        end
        if (cv && cp != 0) begin
            flog.push_back(cp);
            tail_abs++;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rename(input int rw);
        drive(1, 0, 0, 1, 0, 0, rw, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented response against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            check("ren_ready", int'(ren_ready), int'(me.ready));
            check("free_count", int'(free_count), me.cnt);
            check("rs_phys", int'(rs_phys), me.rs);
            check("rt_phys", int'(rt_phys), me.rt);
            if (me.fire) begin
                check("rw_phys", int'(rw_phys), me.rw);
                check("prev_phys", int'(prev_phys), me.prev);
                check("prev_arch", int'(prev_arch), me.arch);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        reset_dut();
        #1 check("reset_free_count", int'(free_count), 32);

        // First two renames of r5.
        drive(1, 1, 0, 1, 3, 0, 5, 0, 0, 0, 0, 0, 0);
        #1 check("first_rw_phys", int'(rw_phys), 32);
        check("first_prev_phys", int'(prev_phys), 5);
        check("reset_map_rs3", int'(rs_phys), 3);
        rename(5);
        #1 check("second_rw_phys", int'(rw_phys), 33);
        check("second_prev_phys", int'(prev_phys), 32);
        idle();
        #1 check("count_after_two", int'(free_count), 30);

        // Source equal to destination reads the old mapping; r0 never allocates.
        drive(1, 1, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0, 0);
        #1 check("rs_eq_rw_old", int'(rs_phys), 7);
        rename(0);
        #1 check("rw0_phys", int'(rw_phys), 0);
        idle();
        #1 check("count_rw0_unchanged", int'(free_count), 29);

        // Exhaust the free list, then free 40 in the stalled cycle.
        for (int i = 0; i < 29; i++) rename(1 + (i % 31));
        drive(1, 0, 0, 1, 0, 0, 4, 1, 40, 0, 0, 0, 0);
        #1 check("empty_ready", int'(ren_ready), 0);
        check("empty_count", int'(free_count), 0);
        rename(6);
        #1 check("refill_ready", int'(ren_ready), 1);
        check("refill_rw_phys", int'(rw_phys), 40);

        // Checkpoint after three renames, two more renames of r9, then restore.
        reset_dut();
        rename(1); rename(2); rename(3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        rename(9); rename(9);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("restored_map9", int'(rs_phys), 9);
        check("restored_count", int'(free_count), 29);

        // Restore, commit and rename in one cycle.
        drive(1, 0, 0, 1, 0, 0, 4, 1, 12, 0, 0, 1, 1);
        #1 check("restore_stalls_rename", int'(ren_ready), 0);
        idle();
        #1 check("restore_commit_count", int'(free_count), 30);

`ifdef RENAME_PERF_CNT_EN
        reset_dut();
        for (int i = 0; i < 32; i++) rename(1 + (i % 31));
        for (int i = 0; i < 5; i++) rename(2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        #1 check("stall_cycles_directed", int'(stall_cycles), 5);
        check("restore_count_directed", int'(restore_count), 2);
`endif

        // Randomised traffic against the model.
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            bit v, urs, urt, urw, cv, ct, rv;
            int rs, rt, rw, cp, cid, rid, cnt;
            v   = ($urandom_range(0, 9) < 7);
            urs = 1'($urandom_range(0, 1));
            urt = 1'($urandom_range(0, 1));
            urw = ($urandom_range(0, 9) < 8);
            rs  = $urandom_range(0, NA - 1);
            rt  = $urandom_range(0, NA - 1);
            rw  = $urandom_range(0, NA - 1);
            cnt = tail_abs - head_abs;
            cv  = ($urandom_range(0, 9) < ((cnt < 8) ? 7 : 3));
            cp  = $urandom_range(0, NP - 1);
            if (cv && cp != 0 && (tail_abs + 1 - head_abs) > F) cv = 0;
            ct  = ($urandom_range(0, 9) < 2);
            cid = $urandom_range(0, NC - 1);
            rv  = ($urandom_range(0, 99) < 8);
            rid = $urandom_range(0, NC - 1);
            if (rv && (tail_abs + ((cv && cp != 0) ? 1 : 0) - ck_head[rid]) > F) rv = 0;
            drive(v, urs, urt, urw, rs, rt, rw, cv, cp, ct, cid, rv, rid);
        end
        idle();
`ifdef RENAME_PERF_CNT_EN
        #1 check("stall_cycles_random", int'(stall_cycles), m_stall);
        check("restore_count_random", int'(restore_count), m_rest);
`endif

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_rename_unit.md
Name: reg_rename_unit

Overview:
- Clocked, parametrised register renaming stage between decode and issue; successor to the single-cycle combinational map table.
- Holds the architectural-to-physical map table, a circular free-list FIFO and NUM_CKPT map/free-list snapshots for branch-mispredict recovery.
- Returns physical registers released at commit to the free list and reports the displaced mapping for the active list.

Parameters:
- NUM_ARCH, 32, architectural register count; arch reg 0 is never renamed.
- NUM_PHYS, 64, physical register count; must be greater than NUM_ARCH.
- NUM_CKPT, 4, number of checkpoint slots.
- Derived: AW = clog2(NUM_ARCH), PW = clog2(NUM_PHYS), CW = clog2(NUM_CKPT), FREE_DEPTH = NUM_PHYS - NUM_ARCH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- ren_valid  in  1  decoded instruction present.
- ren_ready  out  1  rename can accept an instruction this cycle.
- uses_rs, uses_rt, uses_rw  in  1 each  operand and destination use bits.
- rs_arch, rt_arch, rw_arch  in  AW each  architectural register addresses.
- rs_phys, rt_phys  out  PW each  source physical registers; 0 when the source is unused.
- rw_phys  out  PW  newly allocated destination; 0 when uses_rw=0 or rw_arch=0.
- prev_phys  out  PW  displaced mapping of rw_arch, sent to the active list.
- prev_arch  out  AW  equals rw_arch.
- commit_free_valid  in  1  commit releases a physical register.
- commit_free_phys  in  PW  physical register being released.
- ckpt_take  in  1  snapshot current state into slot ckpt_id.
- ckpt_id  in  CW  slot for ckpt_take.
- restore_valid  in  1  mispredict; restore from slot restore_id.
- restore_id  in  CW  slot for restore_valid.
- free_count  out  PW+1  number of free physical registers.

Behaviour:
- Reset, synchronous with rst_n=0 at the clock edge:
  - map[i] = i for every architectural register.
  - Free FIFO holds NUM_ARCH..NUM_PHYS-1 in ascending order; head=0, tail=FREE_DEPTH (pointers carry one wrap bit).
  - free_count = FREE_DEPTH; checkpoint slots are cleared to the reset map.
  - Reset overrides every other input in that cycle.
- Lookup is combinational from the registered map:
  - rs_phys, rt_phys and prev_phys are read before this cycle's write.
  - When rs_arch == rw_arch, rs_phys returns the old mapping. rt_phys follows the same rule.
- Allocation:
  - Allocation is needed when uses_rw=1 and rw_arch != 0.
  - rw_phys = fifo[head]. At the clock edge with fire = ren_valid & ren_ready: map[rw_arch] <= rw_phys and head++.
- Handshake:
  - ren_ready = !restore_valid & (free_count != 0 | no allocation needed).
  - When fire=0, no state changes.
  - rw_phys and prev_phys are valid only while fire=1.
- Commit:
  - When commit_free_valid=1, fifo[tail] <= commit_free_phys and tail++.
  - Commit proceeds in every cycle, including restore and rename cycles.
  - Pushing phys 0 is ignored.
- free_count = tail - head, modulo 2*FREE_DEPTH.
  - Rename and commit in the same cycle leave the count unchanged.
  - Wrap-around is handled by the pointer wrap bit.
- Checkpoint:
  - ckpt_take saves map and head into slot ckpt_id.
  - When fire=1 in the same cycle, the snapshot includes that cycle's rename (post-update map and head).
- Restore:
  - restore_valid takes priority over rename. It loads map and head from slot restore_id.
  - tail is not restored; same-cycle commit still pushes.
  - Allocations made after the checkpoint are reclaimed implicitly.
  - ckpt_take in a restore cycle is ignored.

Optional Feature:
- Macro RENAME_PERF_CNT_EN.
- Defined: adds outputs stall_cycles [31:0] (counts ren_valid & !ren_ready) and restore_count [15:0].
  - Both are zero at reset and saturate at their maximum value.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_core_pkg:
  - PhysReg typedef [PW-1:0], CkptId typedef, NUM_PHYS/NUM_CKPT defaults.
  - Existing MipsReg is reused for architectural addresses.
- Sub-module rename_free_list: circular FIFO with pop, push, head snapshot-restore and count. The map table and checkpoints stay in the top.

Test Plan:
- Reset, then rename add rw=5 → rw_phys=32, prev_phys=5. Next rename rw=5 → rw_phys=33, prev_phys=32; free_count=30.
- Rename with rs=rw=7 → rs_phys=7 (old mapping). rw_arch=0 → rw_phys=0, free_count unchanged.
- 32 back-to-back renames → ren_ready=0 with free_count=0. Commit frees 40 → ren_ready=1; next rename gets 40.
- ckpt_take id=1 after 3 renames; rename rw=9 twice; restore id=1 → map[9] equals its pre-checkpoint value and free_count is back to 29.
- Restore, commit of phys 12 and ren_valid in the same cycle → rename is stalled, 12 is appended, and tail advances by 1.
- With RENAME_PERF_CNT_EN: 5 stalled cycles and 2 restores → stall_cycles=5, restore_count=2.
